// File: rtl/multi_channel_toggle_divider.sv
// rtl/multi_channel_toggle_divider.sv - bank of programmable-period tick/status dividers
// Each channel wraps every active+1 enabled cycles; period updates are staged in pending.
module multi_channel_toggle_divider #(
    parameter  int N_CH           = 4,
    parameter  int CNT_W          = 8,
    parameter  int DEFAULT_PERIOD = 10,
    localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_clear,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  mode,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  status
);

    localparam logic [CNT_W-1:0] C_DEF = CNT_W'(DEFAULT_PERIOD);

    logic [CNT_W-1:0] r_cnt     [N_CH];
    logic [CNT_W-1:0] r_active  [N_CH];
    logic [CNT_W-1:0] r_pending [N_CH];
    logic [N_CH-1:0]  r_tick;
    logic [N_CH-1:0]  r_status;
    logic [N_CH-1:0]  w_wrap;

    // ">=" lets a counter recover if the active period ever drops below it
    always_comb begin
        w_wrap = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wrap[i] = (r_cnt[i] >= r_active[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i]     <= '0;
                r_active[i]  <= C_DEF;
                r_pending[i] <= C_DEF;
            end
            r_tick   <= '0;
            r_status <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    r_pending[i] <= cfg_period;
                end
                // active always samples the pre-write pending value
                if (sync_clear) begin
                    r_cnt[i]    <= '0;
                    r_tick[i]   <= 1'b0;
                    r_status[i] <= 1'b0;
                    r_active[i] <= r_pending[i];
                end else if (en[i]) begin
                    if (w_wrap[i]) begin
                        r_cnt[i]    <= '0;
                        r_tick[i]   <= 1'b1;
                        r_status[i] <= mode[i] ? 1'b1 : ~r_status[i];
                        r_active[i] <= r_pending[i];
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + 1'b1;
                        r_tick[i] <= 1'b0;
                        if (mode[i]) begin
                            r_status[i] <= 1'b0;
                        end
                    end
                end else begin
                    r_tick[i]   <= 1'b0;
                    r_active[i] <= r_pending[i];
                    if (mode[i]) begin
                        r_status[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign tick   = r_tick;
    assign status = r_status;

endmodule
